vpu_bus_arbiter: RTL and testbench

- Responder side of the VPU DMA handshake (hold / bus_ready / vramcs / VADDR / VDATA).
- Owns the single system memory port and shares it between the CPU and the VPU DMA engine.
- Grants the bus to DMA on request, stalls the CPU via a clock enable, and routes read data back to the VPU.
- After each DMA burst, enforces a minimum CPU window before DMA may be granted again.

---
 rtl/vpu_bus_arbiter.sv | 124 ++++++++++++
 tb/tb_vpu_bus_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/vpu_bus_arbiter.sv
// Purpose: shares the single system memory port between the CPU and the VPU DMA engine (hold/bus_ready handshake).
// Latency: grant takes effect one edge after hold is seen with cooldown expired; read data follows the address by one cycle.
// Backpressure: DMA stalls the CPU via cpu_en; after each burst the CPU keeps the bus for at least MIN_CPU_CYCLES.
module vpu_bus_arbiter #(
    parameter int MIN_CPU_CYCLES = 2,
    parameter int CD_W           = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_do,
    input  logic        cpu_rw,
    input  logic        cpu_vma,
    output logic [7:0]  cpu_di,
    output logic        cpu_en,
    input  logic        dma_hold,
    input  logic        dma_cs,
    input  logic [15:0] dma_addr,
    output logic        dma_ready,
    output logic [7:0]  dma_data,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_do,
    output logic        mem_we,
    output logic        mem_cs,
    input  logic [7:0]  mem_di,
    input  logic        stall_clr,
    output logic [15:0] stall_cycles
);

    typedef enum logic [1:0] {
        ST_CPU   = 2'd0,
        ST_GRANT = 2'd1,
        ST_DMA   = 2'd2
    } state_t;

    localparam logic [CD_W-1:0] CD_INIT = CD_W'(MIN_CPU_CYCLES);

    state_t          state_q, state_d;
    logic [CD_W-1:0] cd_q, cd_d;
    logic            ready_q, ready_d;
    logic [15:0]     stall_q, stall_d;
    logic            owner_dma;

    // Ownership is a pure function of the registered state, so the muxes never glitch on input timing.
    assign owner_dma = (state_q != ST_CPU);
    assign cpu_en    = ~owner_dma;
    assign dma_ready = ready_q;

    // State, cooldown, ready flag and stall counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_CPU;
            cd_q    <= CD_INIT;
            ready_q <= 1'b0;
            stall_q <= 16'd0;
        end else begin
            state_q <= state_d;
            cd_q    <= cd_d;
            ready_q <= ready_d;
            stall_q <= stall_d;
        end
    end

    // Next-state logic: hold is level-sensitive, so a request raised during cooldown simply waits for it to expire.
    always_comb begin
        state_d = state_q;
        cd_d    = cd_q;
        ready_d = 1'b0;
        case (state_q)
            ST_CPU: begin
                if (cd_q != '0) begin
                    cd_d = cd_q - CD_W'(1);
                end
                if (dma_hold && (cd_q == '0)) begin
                    state_d = ST_GRANT;
                end else begin
                    ready_d = (cd_d == '0);
                end
            end
            ST_GRANT: begin
                state_d = ST_DMA;
            end
            ST_DMA: begin
                if (!dma_hold) begin
                    state_d = ST_CPU;
                    cd_d    = CD_INIT;
                end
            end
            default: begin
                state_d = ST_CPU;
                cd_d    = CD_INIT;
            end
        endcase
    end

    // Stall counter: clear wins over increment, increment saturates at all-ones.
    always_comb begin
        stall_d = stall_q;
        if (stall_clr) begin
            stall_d = 16'd0;
        end else if (!cpu_en && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    assign stall_cycles = stall_q;

    // Memory port mux; DMA only ever reads, and a write is suppressed while reset is asserted.
    always_comb begin
        mem_addr = cpu_addr;
        mem_cs   = cpu_vma;
        mem_we   = cpu_vma & ~cpu_rw & cpu_en & ~rst;
        if (owner_dma) begin
            mem_addr = dma_addr;
            mem_cs   = dma_cs;
            mem_we   = 1'b0;
        end
    end

    assign mem_do   = cpu_do;
    assign cpu_di   = mem_di;
    assign dma_data = mem_di;

endmodule

// File: tb/tb_vpu_bus_arbiter.sv
module tb_vpu_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_do;
    logic        cpu_rw;
    logic        cpu_vma;
    logic [7:0]  cpu_di;
    logic        cpu_en;
    logic        dma_hold;
    logic        dma_cs;
    logic [15:0] dma_addr;
    logic        dma_ready;
    logic [7:0]  dma_data;
    logic [15:0] mem_addr;
    logic [7:0]  mem_do;
    logic        mem_we;
    logic        mem_cs;
    logic [7:0]  mem_di;
    logic        stall_clr;
    logic [15:0] stall_cycles;

    vpu_bus_arbiter #(.MIN_CPU_CYCLES(2), .CD_W(4)) dut (
        .clk(clk), .rst(rst),
        .cpu_addr(cpu_addr), .cpu_do(cpu_do), .cpu_rw(cpu_rw), .cpu_vma(cpu_vma),
        .cpu_di(cpu_di), .cpu_en(cpu_en),
        .dma_hold(dma_hold), .dma_cs(dma_cs), .dma_addr(dma_addr),
        .dma_ready(dma_ready), .dma_data(dma_data),
        .mem_addr(mem_addr), .mem_do(mem_do), .mem_we(mem_we), .mem_cs(mem_cs), .mem_di(mem_di),
        .stall_clr(stall_clr), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    // Synchronous RAM, one-cycle read latency.
    logic [7:0] ram [0:65535];
    logic [7:0] rd_q;
    always @(posedge clk) begin
        if (mem_cs) begin
            if (mem_we) ram[mem_addr] <= mem_do;
            else        rd_q <= ram[mem_addr];
        end
    end
    assign mem_di = rd_q;

    typedef struct {
        logic [15:0] cpu_addr;
        logic [7:0]  cpu_do;
        logic        cpu_rw;
        logic        cpu_vma;
        logic        dma_cs;
        logic [15:0] dma_addr;
        logic [15:0] exp_addr;
        logic        exp_cs;
        logic        exp_we;
    } vec_t;

    vec_t       cpu_tab [3];
    vec_t       dma_tab [3];
    logic [7:0] sb [$];
    int         tests = 0;
    int         fails = 0;
    int         en_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input vec_t v);
        cpu_addr = v.cpu_addr;
        cpu_do   = v.cpu_do;
        cpu_rw   = v.cpu_rw;
        cpu_vma  = v.cpu_vma;
        dma_cs   = v.dma_cs;
        dma_addr = v.dma_addr;
        #1;
        check("tab_mem_addr", 32'(mem_addr), 32'(v.exp_addr));
        check("tab_mem_cs",   32'(mem_cs),   32'(v.exp_cs));
        check("tab_mem_we",   32'(mem_we),   32'(v.exp_we));
        check("tab_mem_do",   32'(mem_do),   32'(v.cpu_do));
    endtask

    task automatic sb_check(input string name);
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL %s: scoreboard empty, got %0h", name, dma_data);
        end else begin
            check(name, 32'(dma_data), 32'(sb.pop_front()));
        end
    endtask

    initial begin
        // CPU owner: dma_cs is ignored; DMA owner: CPU writes are blocked.
        cpu_tab[0] = '{16'h1000, 8'h5A, 1'b1, 1'b1, 1'b1, 16'h8000, 16'h1000, 1'b1, 1'b0};
        cpu_tab[1] = '{16'h2000, 8'h00, 1'b0, 1'b0, 1'b1, 16'h8001, 16'h2000, 1'b0, 1'b0};
        cpu_tab[2] = '{16'h3000, 8'h77, 1'b0, 1'b1, 1'b0, 16'h8002, 16'h3000, 1'b1, 1'b1};
        dma_tab[0] = '{16'h1234, 8'hA5, 1'b0, 1'b1, 1'b1, 16'h8003, 16'h8003, 1'b1, 1'b0};
        dma_tab[1] = '{16'h1234, 8'hA5, 1'b0, 1'b1, 1'b0, 16'h4321, 16'h4321, 1'b0, 1'b0};
        dma_tab[2] = '{16'h0000, 8'h3C, 1'b1, 1'b0, 1'b0, 16'h8000, 16'h8000, 1'b0, 1'b0};

        rst = 1'b1; cpu_addr = '0; cpu_do = '0; cpu_rw = 1'b1; cpu_vma = 1'b0;
        dma_hold = 1'b0; dma_cs = 1'b0; dma_addr = '0; stall_clr = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        #1;
        check("rst_cpu_en", 32'(cpu_en), 32'd1);
        check("rst_ready",  32'(dma_ready), 32'd0);
        check("rst_stall",  32'(stall_cycles), 32'd0);
        step();
        check("idle1_ready", 32'(dma_ready), 32'd0);
        check("idle1_en",    32'(cpu_en), 32'd1);
        step();
        check("idle2_ready", 32'(dma_ready), 32'd1);
        check("idle2_en",    32'(cpu_en), 32'd1);

        // Preload burst data through the CPU write path.
        for (int i = 0; i < 4; i++) begin
            cpu_addr = 16'h8000 + 16'(i); cpu_do = 8'h11 + 8'(i); cpu_rw = 1'b0; cpu_vma = 1'b1;
            #1;
            check("preload_we", 32'(mem_we), 32'd1);
            step();
        end
        cpu_vma = 1'b0;

        foreach (cpu_tab[i]) apply(cpu_tab[i]);
        cpu_addr = 16'h8001; cpu_rw = 1'b1; cpu_vma = 1'b1; dma_cs = 1'b0;
        step();
        check("cpu_read", 32'(cpu_di), 32'h12);

        // CPU write in the same cycle the VPU requests the bus.
        cpu_addr = 16'h1234; cpu_do = 8'hA5; cpu_rw = 1'b0; cpu_vma = 1'b1; dma_hold = 1'b1;
        #1;
        check("wr_we",   32'(mem_we), 32'd1);
        check("wr_addr", 32'(mem_addr), 32'h1234);
        check("wr_en",   32'(cpu_en), 32'd1);
        step();
        check("grant_en",    32'(cpu_en), 32'd0);
        check("grant_ready", 32'(dma_ready), 32'd0);
        foreach (dma_tab[i]) apply(dma_tab[i]);
        cpu_vma = 1'b0; dma_cs = 1'b0;
        step();
        check("dma_en",    32'(cpu_en), 32'd0);
        check("dma_stall", 32'(stall_cycles), 32'd1);

        // Burst: each address held two cycles, then read back the CPU-written byte.
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 2; k++) begin
                dma_cs = 1'b1; dma_addr = 16'h8000 + 16'(i);
                sb.push_back(8'h11 + 8'(i));
                #1;
                check("burst_we", 32'(mem_we), 32'd0);
                step();
                sb_check("burst_data");
            end
        end
        dma_addr = 16'h1234;
        sb.push_back(8'hA5);
        step();
        sb_check("readback_a5");
        dma_cs = 1'b0;

        // Release and immediately re-request: CPU must keep the bus through the cooldown.
        dma_hold = 1'b0;
        step();
        check("rel_en", 32'(cpu_en), 32'd1);
        dma_hold = 1'b1;
        en_cnt = 0;
        for (int c = 0; c < 12; c++) begin
            if (!cpu_en) break;
            en_cnt++;
            if (en_cnt <= 2) check("cool_ready", 32'(dma_ready), 32'd0);
            step();
        end
        check("regrant_en",  32'(cpu_en), 32'd0);
        check("cpu_window",  32'(en_cnt), 32'd3);

        // Long stall saturates the counter; clear takes effect on the next edge.
        repeat (70000) step();
        check("sat_stall", 32'(stall_cycles), 32'hFFFF);
        stall_clr = 1'b1;
        step();
        check("clr_stall", 32'(stall_cycles), 32'd0);
        stall_clr = 1'b0;
        step();
        check("post_clr_stall", 32'(stall_cycles), 32'd1);

        // Reset while in DMA.
        rst = 1'b1;
        step();
        check("rstdma_en",    32'(cpu_en), 32'd1);
        check("rstdma_ready", 32'(dma_ready), 32'd0);
        check("rstdma_we",    32'(mem_we), 32'd0);
        check("rstdma_stall", 32'(stall_cycles), 32'd0);
        rst = 1'b0; dma_hold = 1'b0;

        // Hold dropped during GRANT: minimum two-cycle stall.
        step();
        step();
        check("drop_ready", 32'(dma_ready), 32'd1);
        dma_hold = 1'b1;
        step();
        check("drop_grant_en", 32'(cpu_en), 32'd0);
        dma_hold = 1'b0;
        step();
        check("drop_dma_en", 32'(cpu_en), 32'd0);
        step();
        check("drop_rel_en",  32'(cpu_en), 32'd1);
        check("drop_stall",   32'(stall_cycles), 32'd2);
        check("drop_ready0",  32'(dma_ready), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
